handshake_ctrl_rr_arbiter: RTL and testbench

HANDSHAKE_CTRL_RR_ARBITER -- requirements
Module: handshake_ctrl_rr_arbiter

---
 rtl/handshake_ctrl_rr_arbiter.sv | 115 +++++++++++
 tb/tb_handshake_ctrl_rr_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/handshake_ctrl_rr_arbiter.sv
// Round-robin arbiter merging valid/ready control tokens into one registered slot.
// Optional HANDSHAKE_ARB_GRANT_CNT_EN adds a saturating 16-bit accepted-token counter.
module handshake_ctrl_rr_arbiter #(
    parameter int NUM_INPUTS  = 4,
    parameter int INDEX_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_INPUTS-1:0]  ins_valid,
    output logic [NUM_INPUTS-1:0]  ins_ready,
    output logic [INDEX_WIDTH-1:0] index,
    output logic                   index_valid,
    input  logic                   index_ready
`ifdef HANDSHAKE_ARB_GRANT_CNT_EN
    ,
    output logic [15:0]            grant_count
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t            state;
    logic [INDEX_WIDTH-1:0] ptr;
    logic [INDEX_WIDTH-1:0] grant;
    logic [INDEX_WIDTH-1:0] ptr_next;
    logic                   found;
    logic                   can_accept;
    logic                   accept;
    logic                   transfer;

    // Rotating-priority search starting at ptr and wrapping past the top.
    always_comb begin
        int k;
        k     = 0;
        found = 1'b0;
        grant = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            k = int'(ptr) + i;
            if (k >= NUM_INPUTS) begin
                k = k - NUM_INPUTS;
            end
            if (!found && ins_valid[k]) begin
                found = 1'b1;
                grant = INDEX_WIDTH'(k);
            end
        end
    end

    assign transfer   = index_valid && index_ready;
    assign can_accept = (state == EMPTY) || index_ready;
    assign accept     = can_accept && found;

    assign ptr_next = (grant == INDEX_WIDTH'(NUM_INPUTS - 1)) ?
                      '0 : grant + 1'b1;

    // Gated by rst so no requester sees acceptance while reset is held.
    always_comb begin
        ins_ready = '0;
        if (rst && accept) begin
            ins_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= EMPTY;
            index       <= '0;
            index_valid <= 1'b0;
            ptr         <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state       <= FULL;
                        index       <= grant;
                        index_valid <= 1'b1;
                        ptr         <= ptr_next;
                    end
                end
                FULL: begin
                    if (accept) begin
                        index       <= grant;
                        index_valid <= 1'b1;
                        ptr         <= ptr_next;
                    end else if (transfer) begin
                        state       <= EMPTY;
                        index_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    index_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef HANDSHAKE_ARB_GRANT_CNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (accept && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign grant_count = count_q;
`endif

endmodule

// File: tb/tb_handshake_ctrl_rr_arbiter.sv
// Directed self-checking bench for handshake_ctrl_rr_arbiter (NUM_INPUTS=4).
// Counter checks run only when HANDSHAKE_ARB_GRANT_CNT_EN is defined.
module tb_handshake_ctrl_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] ins_valid;
    logic [3:0] ins_ready;
    logic [1:0] index;
    logic       index_valid;
    logic       index_ready;
`ifdef HANDSHAKE_ARB_GRANT_CNT_EN
    logic [15:0] grant_count;
`endif

    int total;
    int bad;

    handshake_ctrl_rr_arbiter #(
        .NUM_INPUTS (4),
        .INDEX_WIDTH(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .index      (index),
        .index_valid(index_valid),
        .index_ready(index_ready)
`ifdef HANDSHAKE_ARB_GRANT_CNT_EN
        ,
        .grant_count(grant_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b0;
        ins_valid   = 4'b0000;
        index_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(index_valid), 32'h0);
        chk("rst_index", 32'(index), 32'h0);
        ins_valid   = 4'b1111;
        index_ready = 1'b1;
        #1;
        chk("rst_ready_zero", 32'(ins_ready), 32'h0);

        // All requesters active: 0,1,2,3,0,1
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("first_grant_0", 32'(ins_ready), 32'h1);
        chk("empty_after_rst", 32'(index_valid), 32'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rr_valid", 32'(index_valid), 32'h1);
            chk("rr_index", 32'(index), 32'(k % 4));
            chk("rr_ready", 32'(ins_ready), 32'(1 << ((k + 1) % 4)));
        end

        // Sparse requests 1010: ptr is 2 so grant 3 first
        ins_valid = 4'b1010;
        #1;
        chk("alt_ready0", 32'(ins_ready), 32'h8);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("alt_index", 32'(index), (k % 2 == 0) ? 32'h3 : 32'h1);
            chk("alt_ready", 32'(ins_ready), (k % 2 == 0) ? 32'h2 : 32'h8);
        end

        // Load index 2, then stall with everything requesting
        ins_valid = 4'b0100;
        #1;
        chk("load2_ready", 32'(ins_ready), 32'h4);
        @(negedge clk);
        chk("load2_index", 32'(index), 32'h2);
        index_ready = 1'b0;
        ins_valid   = 4'b1111;
        #1;
        chk("stall_ready0", 32'(ins_ready), 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_index", 32'(index), 32'h2);
            chk("stall_valid", 32'(index_valid), 32'h1);
            chk("stall_ready", 32'(ins_ready), 32'h0);
        end
        index_ready = 1'b1;
        #1;
        chk("release_grant3", 32'(ins_ready), 32'h8);
        @(negedge clk);
        chk("release_index", 32'(index), 32'h3);
        chk("release_next", 32'(ins_ready), 32'h1);

        // Reset while FULL with requests pending
        rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(index_valid), 32'h0);
        chk("midrst_index", 32'(index), 32'h0);
        chk("midrst_ready", 32'(ins_ready), 32'h0);
        @(negedge clk);
        chk("midrst_hold", 32'(index_valid), 32'h0);
        rst = 1'b1;
        #1;
        chk("postrst_valid", 32'(index_valid), 32'h0);
        chk("postrst_grant", 32'(ins_ready), 32'h1);
        @(negedge clk);
        chk("postrst_index", 32'(index), 32'h0);
        chk("postrst_v1", 32'(index_valid), 32'h1);

        // Single requester 3 toggling
        ins_valid = 4'b1000;
        #1;
        chk("tog_ready", 32'(ins_ready), 32'h8);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("tog_index", 32'(index), 32'h3);
            chk("tog_valid", 32'(index_valid), 32'h1);
            ins_valid = 4'b0000;
            #1;
            chk("tog_idle_ready", 32'(ins_ready), 32'h0);
            @(negedge clk);
            chk("tog_empty", 32'(index_valid), 32'h0);
            ins_valid = 4'b1000;
            #1;
            chk("tog_reaccept", 32'(ins_ready), 32'h8);
        end
        @(negedge clk);
        ins_valid = 4'b0000;
        @(negedge clk);
        chk("tog_final_empty", 32'(index_valid), 32'h0);

        // EMPTY slot accepts even with downstream not ready
        index_ready = 1'b0;
        ins_valid   = 4'b0001;
        #1;
        chk("empty_nr_ready", 32'(ins_ready), 32'h1);
        @(negedge clk);
        chk("empty_nr_index", 32'(index), 32'h0);
        chk("empty_nr_valid", 32'(index_valid), 32'h1);
        chk("full_nr_ready", 32'(ins_ready), 32'h0);

`ifdef HANDSHAKE_ARB_GRANT_CNT_EN
        rst = 1'b0;
        #1;
        chk("cnt_rst", 32'(grant_count), 32'h0);
        @(negedge clk);
        rst         = 1'b1;
        ins_valid   = 4'b1111;
        index_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("cnt_10", 32'(grant_count), 32'd10);
        repeat (69990) @(negedge clk);
        chk("cnt_sat", 32'(grant_count), 32'hFFFF);
        rst = 1'b0;
        #1;
        chk("cnt_clear", 32'(grant_count), 32'h0);
        @(negedge clk);
        rst = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
